iir2_prog: RTL and testbench



---
 rtl/iir2_prog.sv | 126 ++++++++++++
 tb/tb_iir2_prog.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/iir2_prog.sv
// Second-order direct-form-I IIR filter with run-time programmable coefficients.
// Computes y = (b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2) >>> FRAC, with one cycle of latency.
// Optional feature: define IIR2_PROG_SAT_EN to saturate the result to NB bits.
// When it is undefined, the result wraps to NB bits instead.
module iir2_prog #(
  parameter int unsigned NB   = 12,
  parameter int unsigned FRAC = 11
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic signed [NB-1:0] DIN,
  input  logic                 VIN,
  input  logic                 CLR,
  input  logic                 COEF_WE,
  input  logic [2:0]           COEF_ADDR,
  input  logic signed [NB-1:0] COEF_DATA,
  output logic signed [NB-1:0] DOUT,
  output logic                 VOUT
);

  localparam int unsigned PW = 2 * NB;
  localparam int unsigned AW = 2 * NB + 3;

  // Coefficient registers
  logic signed [NB-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;
  // Filter history and output registers
  logic signed [NB-1:0] x1_q, x2_q, y1_q, y2_q, dout_q;
  logic                 vout_q;

  logic signed [PW-1:0] p_b0, p_b1, p_b2, p_a1, p_a2;
  logic signed [AW-1:0] acc;
  logic signed [NB-1:0] result;

  // Sign-extend an NB-bit value to product width
  function automatic logic signed [PW-1:0] ext_p(input logic signed [NB-1:0] v);
    return {{(PW - NB){v[NB-1]}}, v};
  endfunction

  // Sign-extend a product to accumulator width
  function automatic logic signed [AW-1:0] ext_a(input logic signed [PW-1:0] v);
    return {{(AW - PW){v[PW-1]}}, v};
  endfunction

  // Products and full-precision accumulation; feedback terms are subtracted
  always_comb begin
    p_b0 = ext_p(b0_q) * ext_p(DIN);
    p_b1 = ext_p(b1_q) * ext_p(x1_q);
    p_b2 = ext_p(b2_q) * ext_p(x2_q);
    p_a1 = ext_p(a1_q) * ext_p(y1_q);
    p_a2 = ext_p(a2_q) * ext_p(y2_q);
    acc  = ext_a(p_b0) + ext_a(p_b1) + ext_a(p_b2) - ext_a(p_a1) - ext_a(p_a2);
  end

`ifdef IIR2_PROG_SAT_EN
  logic signed [AW-1:0] shifted;

  // Arithmetic shift, then clamp when the upper bits are not a pure sign extension
  always_comb begin
    shifted = acc >>> FRAC;
    if ((&shifted[AW-1:NB-1]) || !(|shifted[AW-1:NB-1])) begin
      result = shifted[NB-1:0];
    end else if (shifted[AW-1]) begin
      result = {1'b1, {(NB - 1){1'b0}}};
    end else begin
      result = {1'b0, {(NB - 1){1'b1}}};
    end
  end
`else
  // Arithmetic shift, keep the low NB bits (wrap)
  always_comb begin
    result = NB'(acc >>> FRAC);
  end
`endif

  // Coefficient write port; addresses 5-7 are ignored and CLR does not block writes
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      b0_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
    end else if (COEF_WE) begin
      case (COEF_ADDR)
        3'd0:    b0_q <= COEF_DATA;
        3'd1:    b1_q <= COEF_DATA;
        3'd2:    b2_q <= COEF_DATA;
        3'd3:    a1_q <= COEF_DATA;
        3'd4:    a2_q <= COEF_DATA;
        default: ;
      endcase
    end
  end

  // Filter state: CLR wins over VIN, the feedback path stores the reduced result
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      x1_q   <= '0;
      x2_q   <= '0;
      y1_q   <= '0;
      y2_q   <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
    end else if (CLR) begin
      x1_q   <= '0;
      x2_q   <= '0;
      y1_q   <= '0;
      y2_q   <= '0;
      dout_q <= '0;
      vout_q <= 1'b0;
    end else if (VIN) begin
      x2_q   <= x1_q;
      x1_q   <= DIN;
      y2_q   <= y1_q;
      y1_q   <= result;
      dout_q <= result;
      vout_q <= 1'b1;
    end else begin
      vout_q <= 1'b0;
    end
  end

  assign DOUT = dout_q;
  assign VOUT = vout_q;

endmodule

// File: tb/tb_iir2_prog.sv
// Directed bench for iir2_prog: expected outputs are queued when a sample is driven
// and compared one cycle later when VOUT should fire.
module tb_iir2_prog;

  localparam int NB = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [NB-1:0] din = '0;
  logic                 vin = 1'b0;
  logic                 clr = 1'b0;
  logic                 coef_we = 1'b0;
  logic [2:0]           coef_addr = '0;
  logic signed [NB-1:0] coef_data = '0;
  logic signed [NB-1:0] dout;
  logic                 vout;

  int                 total = 0;
  int                 bad = 0;
  int                 expq[$];
  logic signed [31:0] last_dout = 0;

  iir2_prog #(.NB(NB), .FRAC(11)) dut (
    .CLK       (clk),
    .RST_n     (rst_n),
    .DIN       (din),
    .VIN       (vin),
    .CLR       (clr),
    .COEF_WE   (coef_we),
    .COEF_ADDR (coef_addr),
    .COEF_DATA (coef_data),
    .DOUT      (dout),
    .VOUT      (vout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus followed by the output check
  task automatic step(input string tag, input logic v, input int d, input logic c,
                      input logic we, input logic [2:0] a, input int cd, input int exp);
    din       = d[NB-1:0];
    vin       = v;
    clr       = c;
    coef_we   = we;
    coef_addr = a;
    coef_data = cd[NB-1:0];
    if (c) begin
      expq.delete();
      last_dout = 0;
    end else if (v) begin
      expq.push_back(exp);
    end
    @(posedge clk);
    #1;
    vin     = 1'b0;
    clr     = 1'b0;
    coef_we = 1'b0;
    if (expq.size() > 0) begin
      chk({tag, ".vout"}, vout, 1);
      last_dout = expq.pop_front();
      chk({tag, ".dout"}, dout, last_dout);
    end else begin
      chk({tag, ".vout"}, vout, 0);
      chk({tag, ".hold"}, dout, last_dout);
    end
  endtask

  task automatic smp(input string tag, input int d, input int exp);
    step(tag, 1'b1, d, 1'b0, 1'b0, 3'd0, 0, exp);
  endtask

  task automatic wr(input logic [2:0] a, input int cd);
    step("wr", 1'b0, 0, 1'b0, 1'b1, a, cd, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 0, 1'b0, 1'b0, 3'd0, 0, 0);
  endtask

  initial begin
    int ovf_exp;
`ifdef IIR2_PROG_SAT_EN
    ovf_exp = 2047;
`else
    ovf_exp = -4;
`endif
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.dout", dout, 0);
    chk("rst.vout", vout, 0);
    rst_n = 1'b1;
    idle(10);

    // Coefficient write in the same cycle as a sample uses the old b0 (0)
    step("cwt", 1'b1, 1000, 1'b0, 1'b1, 3'd0, 1024, 0);
    smp("cwt2", 1000, 500);
    // Address 6 must not alter any coefficient (b1 would see x1=1000)
    wr(3'd6, 2047);
    smp("addr6", 1000, 500);

    // Feed-forward gain of 0.5
    smp("ffpos", 1000, 500);
    smp("ffneg", -1000, -500);

    // Recursive impulse with a1 = -0.5, with an idle gap in the middle
    wr(3'd3, -1024);
    step("clr0", 1'b0, 0, 1'b1, 1'b0, 3'd0, 0, 0);
    smp("imp0", 2000, 1000);
    smp("imp1", 0, 500);
    idle(5);
    smp("imp2", 0, 250);
    smp("imp3", 0, 125);

    // CLR beats a same-cycle sample, history gone, coefficients kept
    step("clrv", 1'b1, 2000, 1'b1, 1'b0, 3'd0, 0, 0);
    smp("clrz", 0, 0);
    smp("clrk", 2000, 1000);

    // Overflow: b0 = b1 = 2047, no feedback
    wr(3'd3, 0);
    wr(3'd0, 2047);
    wr(3'd1, 2047);
    step("clr1", 1'b0, 0, 1'b1, 1'b0, 3'd0, 0, 0);
    smp("ovf0", 2047, 2046);
    smp("ovf1", 2047, ovf_exp);

    // CLR together with a coefficient write: the write still lands
    step("clrwe", 1'b0, 0, 1'b1, 1'b1, 3'd0, 1024, 0);
    smp("clrwe2", 1000, 500);

    // Mid-stream reset clears outputs at once; (1024+2047)*1000 >>> 11 = 1499
    smp("pre", 1000, 1499);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.dout", dout, 0);
    chk("midrst.vout", vout, 0);
    expq.delete();
    last_dout = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    // Coefficients were reset too
    smp("postrst", 1000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
